key_input_port: RTL and testbench
=================================

Name: key_input_port

Overview:
- Debounced push-button input peripheral; the input-side companion to the LED output port.
- Sits on the SoC Wishbone bus as a slave. Synchronises and debounces PORT_WIDTH raw key pins and latches press events.
- Raises a level interrupt to the processor for unmasked presses.
- Key pins connect directly at top level, e.g. KEY[0] on the board.

Parameters:
- PORT_WIDTH, 1, number of key inputs.
- Dw, 32, Wishbone data width; must be >= PORT_WIDTH.
- Aw, 2, Wishbone word-address width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be >= 2.
- ACTIVE_LOW, 1, 1 = pin low means pressed; 0 = pin high means pressed.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- key_port_i  input  PORT_WIDTH  raw, asynchronous key pins.
- sa_dat_i  input  Dw  write data.
- sa_sel_i  input  Dw/8  byte selects; ignored, full-word access.
- sa_addr_i  input  Aw  word address.
- sa_stb_i  input  1  strobe.
- sa_cyc_i  input  1  cycle.
- sa_we_i  input  1  write enable.
- sa_dat_o  output  Dw  read data.
- sa_ack_o  output  1  acknowledge.
- sa_err_o  output  1  tied 0.
- sa_rty_o  output  1  tied 0.
- irq  output  1  level interrupt.

Behaviour:
- Reset (reset low, async): all registers clear.
  - sa_ack_o=0, sa_dat_o=0, irq=0.
  - Synchroniser flops load the released level, so no spurious press after reset.
  - Debounced state = all released; counters = 0; EDGE=0; MASK=0.
- Pressed-polarity normalisation: p = ACTIVE_LOW ? ~pin : pin, applied before synchronising.
- Synchroniser: 2-FF per bit on p, giving s[i]. Latency 2 clk.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES):
  - s==stable: cnt<=0.
  - s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - A change is accepted after exactly DEBOUNCE_CYCLES consecutive differing samples. Any glitch back to the stable level restarts the count.
- Press event: stable transitions 0->1; release transitions are not captured.
  - EDGE[i] is set in the cycle after stable[i] rises.
- Register map (word address):
  - 0 DATA (RO): stable[PORT_WIDTH-1:0], zero-extended.
  - 1 EDGE (W1C): a write of 1 clears that bit. If a press and a clear hit the same bit in the same cycle, the set wins.
  - 2 MASK (RW): interrupt enable per bit.
  - 3 RAW (RO): synchronised s, undebounced.
  - Writes to RO addresses are ignored and still acked.
- Bus handshake:
  - When sa_stb_i & sa_cyc_i & ~sa_ack_o: ack asserts the next cycle for one cycle, and sa_dat_o is registered with read data in that same cycle.
  - Write takes effect on the ack edge.
  - Ack always drops for at least one cycle between transfers: back-to-back strobe gives ack every 2nd cycle.
  - sa_dat_o returns 0 when not acking.
- irq: registered |(EDGE & MASK); asserts 1 cycle after the contributing bit is set. It clears 1 cycle after the EDGE bit is cleared or the MASK bit is cleared.
- Reset mid-operation: all state is abandoned immediately, and a partially counted debounce is discarded. A key held pressed through reset deassertion is reported as a press once DEBOUNCE_CYCLES have elapsed after synchronisation.

Test Plan:
- DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, PORT_WIDTH=1. Pin driven 1->0 and held → DATA reads 1 starting 2+4 clk after the edge (±1 sample). EDGE=1. irq stays 0 while MASK=0.
- Same config, pin pulses low for 3 clk then returns high → DATA stays 0, EDGE stays 0, RAW shows the pulse.
- MASK write 1, then a press → irq=1 one cycle after EDGE sets. Write 1 to EDGE → irq=0 within 2 clk. Write 0 to EDGE instead → EDGE and irq stay 1.
- Press completes debounce in the same cycle as an EDGE W1C write → EDGE remains 1, irq remains 1.
- Back-to-back reads of addr 0,1,2,3 with stb held → ack pattern 1,0,1,0,…; data = DATA, EDGE, MASK, RAW. err=rty=0 throughout.
- Assert reset low mid-debounce (cnt=2) while the pin is held low → all outputs 0 immediately. After release, DATA rises 6 clk later and EDGE sets.

Source files
------------

// File: rtl/key_input_port.sv
// Debounced push-button input port on a Wishbone slave interface.
// Latches press events into a W1C register and raises a masked level interrupt.
module key_input_port #(
   parameter int PORT_WIDTH      = 1,
   parameter int Dw              = 32,
   parameter int Aw              = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PORT_WIDTH-1:0] key_port_i,
   input  logic [Dw-1:0]         sa_dat_i,
   input  logic [Dw/8-1:0]       sa_sel_i,
   input  logic [Aw-1:0]         sa_addr_i,
   input  logic                  sa_stb_i,
   input  logic                  sa_cyc_i,
   input  logic                  sa_we_i,
   output logic [Dw-1:0]         sa_dat_o,
   output logic                  sa_ack_o,
   output logic                  sa_err_o,
   output logic                  sa_rty_o,
   output logic                  irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [PORT_WIDTH-1:0] pressed;
   logic [PORT_WIDTH-1:0] sync1;
   logic [PORT_WIDTH-1:0] sync2;
   logic [PORT_WIDTH-1:0] stable;
   logic [PORT_WIDTH-1:0] stable_d;
   logic [PORT_WIDTH-1:0] edge_q;
   logic [PORT_WIDTH-1:0] mask_q;
   logic [PORT_WIDTH-1:0] rise;
   logic [PORT_WIDTH-1:0] clr;
   logic [CW-1:0]         cnt [PORT_WIDTH];
   logic                  req;
   logic                  wr;
   logic [Dw-1:0]         rd_data;
   logic                  unused_in;

   assign pressed   = (ACTIVE_LOW != 0) ? ~key_port_i : key_port_i;
   assign unused_in = ^{sa_sel_i, sa_dat_i};

   assign sa_err_o = 1'b0;
   assign sa_rty_o = 1'b0;

   // Normalised domain: 0 is released, so reset leaves no phantom press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pressed;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable   <= '0;
         stable_d <= '0;
         for (int unsigned i = 0; i < PORT_WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable_d <= stable;
         for (int unsigned i = 0; i < PORT_WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign rise = stable & ~stable_d;
   assign req  = sa_stb_i & sa_cyc_i & ~sa_ack_o;
   assign wr   = req & sa_we_i;
   assign clr  = (wr && sa_addr_i == Aw'(1)) ? sa_dat_i[PORT_WIDTH-1:0] : '0;

   always_comb begin
      rd_data = '0;
      case (sa_addr_i)
         Aw'(0):  rd_data[PORT_WIDTH-1:0] = stable;
         Aw'(1):  rd_data[PORT_WIDTH-1:0] = edge_q;
         Aw'(2):  rd_data[PORT_WIDTH-1:0] = mask_q;
         Aw'(3):  rd_data[PORT_WIDTH-1:0] = sync2;
         default: rd_data = '0;
      endcase
   end

   // A press landing on the same edge as a W1C clear is kept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q <= '0;
         mask_q <= '0;
         irq    <= 1'b0;
      end else begin
         edge_q <= (edge_q & ~clr) | rise;
         if (wr && sa_addr_i == Aw'(2)) begin
            mask_q <= sa_dat_i[PORT_WIDTH-1:0];
         end
         irq <= |(edge_q & mask_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sa_ack_o <= 1'b0;
         sa_dat_o <= '0;
      end else begin
         sa_ack_o <= req;
         sa_dat_o <= req ? rd_data : '0;
      end
   end

endmodule

// File: tb/tb_key_input_port.sv
// Bench for key_input_port: debounce timing, W1C edge register, mask/irq,
// back-to-back bus reads and mid-debounce reset, checked via a read scoreboard.
module tb_key_input_port;

   localparam int DBC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [0:0]  key_port_i;
   logic [31:0] sa_dat_i;
   logic [3:0]  sa_sel_i;
   logic [1:0]  sa_addr_i;
   logic        sa_stb_i;
   logic        sa_cyc_i;
   logic        sa_we_i;
   logic [31:0] sa_dat_o;
   logic        sa_ack_o;
   logic        sa_err_o;
   logic        sa_rty_o;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   bit          rd_q[$];

   key_input_port #(
      .PORT_WIDTH      (1),
      .Dw              (32),
      .Aw              (2),
      .DEBOUNCE_CYCLES (DBC),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_port_i (key_port_i),
      .sa_dat_i   (sa_dat_i),
      .sa_sel_i   (sa_sel_i),
      .sa_addr_i  (sa_addr_i),
      .sa_stb_i   (sa_stb_i),
      .sa_cyc_i   (sa_cyc_i),
      .sa_we_i    (sa_we_i),
      .sa_dat_o   (sa_dat_o),
      .sa_ack_o   (sa_ack_o),
      .sa_err_o   (sa_err_o),
      .sa_rty_o   (sa_rty_o),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Every ack retires one scoreboard entry; read entries carry expected data.
   always @(negedge clk) begin
      if (reset && sa_ack_o) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [31:0] e;
            bit          r;
            e = exp_q.pop_front();
            r = rd_q.pop_front();
            if (r) check_eq("rd_data", sa_dat_o, e);
         end
      end
   end

   task automatic bus_xfer(input logic we, input logic [1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp);
      bit got;
      exp_q.push_back(exp);
      rd_q.push_back(!we);
      sa_we_i   = we;
      sa_addr_i = addr;
      sa_dat_i  = wdata;
      sa_stb_i  = 1'b1;
      sa_cyc_i  = 1'b1;
      got = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1;
         if (sa_ack_o) got = 1;
      end
      if (!got) check_eq("ack_timeout", 32'(got), 32'd1);
      sa_stb_i = 1'b0;
      sa_cyc_i = 1'b0;
      sa_we_i  = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp);
      bus_xfer(1'b0, addr, 32'd0, exp);
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] wdata);
      bus_xfer(1'b1, addr, wdata, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacks;
      reset      = 1'b0;
      key_port_i = 1'b1;
      sa_dat_i   = '0;
      sa_sel_i   = 4'hF;
      sa_addr_i  = '0;
      sa_stb_i   = 1'b0;
      sa_cyc_i   = 1'b0;
      sa_we_i    = 1'b0;

      tick(2);
      check_eq("rst_ack", 32'(sa_ack_o), 32'd0);
      check_eq("rst_dat", sa_dat_o, 32'd0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_err", 32'(sa_err_o), 32'd0);
      check_eq("rst_rty", 32'(sa_rty_o), 32'd0);
      reset = 1'b1;
      tick(3);
      bus_read(2'd0, 32'd0);
      bus_read(2'd1, 32'd0);
      bus_read(2'd2, 32'd0);

      // Clean press: stable rises 2+DBC edges after the pin edge.
      tick(1);
      key_port_i = 1'b0;
      tick(4);
      bus_read(2'd0, 32'd0);
      bus_read(2'd0, 32'd1);
      bus_read(2'd1, 32'd1);
      bus_read(2'd3, 32'd1);
      bus_read(2'd2, 32'd0);
      check_eq("irq_masked", 32'(irq), 32'd0);

      // Release is not an event; then clear EDGE.
      key_port_i = 1'b1;
      tick(12);
      bus_read(2'd0, 32'd0);
      bus_read(2'd1, 32'd1);
      bus_write(2'd1, 32'd1);
      bus_read(2'd1, 32'd0);

      // 3-cycle glitch: visible on RAW, rejected by debounce.
      tick(1);
      key_port_i = 1'b0;
      tick(2);
      bus_read(2'd3, 32'd1);
      key_port_i = 1'b1;
      tick(10);
      bus_read(2'd0, 32'd0);
      bus_read(2'd1, 32'd0);

      // Unmasked press drives irq one cycle after EDGE.
      bus_write(2'd2, 32'd1);
      bus_read(2'd2, 32'd1);
      tick(1);
      key_port_i = 1'b0;
      tick(7);
      check_eq("irq_before", 32'(irq), 32'd0);
      tick(1);
      check_eq("irq_set", 32'(irq), 32'd1);
      bus_write(2'd1, 32'd0);
      bus_read(2'd1, 32'd1);
      check_eq("irq_w0_hold", 32'(irq), 32'd1);
      bus_write(2'd1, 32'd1);
      tick(1);
      check_eq("irq_cleared", 32'(irq), 32'd0);
      bus_read(2'd1, 32'd0);

      // Press edge collides with W1C clear: set wins.
      key_port_i = 1'b1;
      tick(12);
      key_port_i = 1'b0;
      tick(6);
      bus_write(2'd1, 32'd1);
      tick(1);
      check_eq("irq_collide", 32'(irq), 32'd1);
      bus_read(2'd1, 32'd1);

      // Back-to-back reads with strobe held: DATA=0 EDGE=1 MASK=1 RAW=0.
      key_port_i = 1'b1;
      tick(12);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] pat;
         pat = 4'b0110;
         exp_q.push_back({31'd0, pat[i]});
         rd_q.push_back(1'b1);
      end
      nacks     = 0;
      sa_we_i   = 1'b0;
      sa_addr_i = 2'd0;
      sa_stb_i  = 1'b1;
      sa_cyc_i  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check_eq("b2b_ack", 32'(sa_ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("b2b_err_rty", 32'({sa_err_o, sa_rty_o}), 32'd0);
         if (sa_ack_o) begin
            nacks++;
            if (nacks == 4) begin
               sa_stb_i = 1'b0;
               sa_cyc_i = 1'b0;
            end else begin
               sa_addr_i = sa_addr_i + 2'd1;
            end
         end
      end

      // Reset mid-debounce with the key held.
      tick(1);
      key_port_i = 1'b0;
      tick(4);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_ack", 32'(sa_ack_o), 32'd0);
      check_eq("mid_rst_dat", sa_dat_o, 32'd0);
      check_eq("mid_rst_irq", 32'(irq), 32'd0);
      tick(2);
      reset = 1'b1;
      tick(4);
      bus_read(2'd0, 32'd0);
      bus_read(2'd0, 32'd1);
      bus_read(2'd1, 32'd1);
      bus_read(2'd2, 32'd0);
      check_eq("post_rst_irq", 32'(irq), 32'd0);

      tick(3);
      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
